// File: rtl/gpca_cell_array.sv
// Registered 9-row add/subtract-shift cellular array: multiply/square by accumulation,
// divide/square root by restoring subtraction. Two-cycle latency, one operation per cycle.
module gpca_cell_array (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        X,
    input  logic [8:0]  P,   // bit 8 is the MSB (row 1)
    input  logic [18:0] B,   // bit 18 is the MSB
    input  logic [18:0] C,   // bit 18 is the MSB, left-justified
    input  logic [17:0] A,
    output logic [8:0]  F,   // bit 8 is row 1's decision
    output logic [18:0] S
);

    logic        x_r;
    logic [8:0]  p_r;
    logic [18:0] b_r, c_r;
    logic [17:0] a_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= 1'b0;
            p_r <= '0;
            b_r <= '0;
            c_r <= '0;
            a_r <= '0;
        end else begin
            x_r <= X;
            p_r <= P;
            b_r <= B;
            c_r <= C;
            a_r <= A;
        end
    end

    logic [18:0] cv;
    logic        fb;
    logic [8:0]  q;
    logic [39:0] term, tw, rem, acc;
    logic        bit_d;
    logic [8:0]  f_c;
    logic [18:0] s_c;

    always_comb begin
        // Cv drops the trailing zeros of the left-justified constant.
        cv = c_r;
        for (int k = 0; k < 18; k++)
            if (cv != '0 && !cv[0])
                cv = cv >> 1;
        fb    = |(b_r & ~c_r);
        q     = '0;
        term  = '0;
        tw    = '0;
        bit_d = 1'b0;
        f_c   = '0;
        rem   = {22'b0, a_r};
        acc   = {22'b0, a_r};
        for (int j = 0; j < 9; j++) begin
            // Row j+1: feedback rows fold the partial root/square into the term.
            if (fb) begin
                term = ({31'b0, q} << 2) + {21'b0, cv};
                tw   = term << (2 * (8 - j));
            end else begin
                term = {21'b0, cv};
                tw   = term << (8 - j);
            end
            if (x_r) begin
                bit_d = (rem >= tw);
                if (bit_d)
                    rem = rem - tw;
            end else begin
                bit_d = p_r[8-j];
                if (bit_d)
                    acc = acc + tw;
            end
            f_c[8-j] = bit_d;
            q        = {q[7:0], bit_d};
        end
        s_c = x_r ? rem[18:0] : acc[18:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F <= '0;
            S <= '0;
        end else begin
            F <= f_c;
            S <= s_c;
        end
    end

endmodule

// File: tb/tb_gpca_cell_array.sv
// Directed bench for gpca_cell_array: reset, multiply, square, root, divide,
// boundary cases and back-to-back pipelining against hand-computed results.
module tb_gpca_cell_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        X;
    logic [8:0]  P;
    logic [18:0] B, C;
    logic [17:0] A;
    logic [8:0]  F;
    logic [18:0] S;

    int total = 0;
    int bad   = 0;

    localparam logic [18:0] MUL7 = {3'b111, 16'b0};
    localparam logic [18:0] SQB  = {2'b00, 17'h1FFFF};
    localparam logic [18:0] SQC  = {2'b01, 17'b0};
    localparam logic [18:0] DIV5 = {3'b101, 16'b0};
    localparam logic [18:0] ONES = 19'h7FFFF;

    gpca_cell_array dut (
        .clk(clk), .rst_n(rst_n), .X(X), .P(P), .B(B), .C(C), .A(A), .F(F), .S(S)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic x, input logic [8:0] p, input logic [17:0] a,
                         input logic [18:0] b, input logic [18:0] c);
        X = x; P = p; A = a; B = b; C = c;
    endtask

    task automatic chk(input string tag, input logic [8:0] fe, input logic [18:0] se);
        total++;
        assert (F === fe) else begin
            bad++;
            $error("FAIL %s F got %0d exp %0d", tag, F, fe);
        end
        total++;
        assert (S === se) else begin
            bad++;
            $error("FAIL %s S got %0d exp %0d", tag, S, se);
        end
    endtask

    // Drive at a negedge, wait the two-edge latency, check, return on a negedge.
    task automatic run1(input string tag, input logic x, input logic [8:0] p,
                        input logic [17:0] a, input logic [18:0] b, input logic [18:0] c,
                        input logic [8:0] fe, input logic [18:0] se);
        apply(x, p, a, b, c);
        @(posedge clk);
        @(posedge clk);
        #1 chk(tag, fe, se);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        apply(1'b0, 9'd5, 18'd10, MUL7, MUL7);
        #3 chk("reset_async", 9'd0, 19'd0);
        @(posedge clk); @(posedge clk);
        #1 chk("reset_held", 9'd0, 19'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("release_edge1", 9'd0, 19'd0);
        @(posedge clk);
        #1 chk("release_edge2", 9'd5, 19'd45);
        @(negedge clk);

        run1("mul_5x7",     1'b0, 9'd5,   18'd0,    MUL7, MUL7, 9'd5,   19'd35);
        run1("mul_5x7_a10", 1'b0, 9'd5,   18'd10,   MUL7, MUL7, 9'd5,   19'd45);
        run1("sq_5",        1'b0, 9'd5,   18'd0,    SQB,  SQC,  9'd5,   19'd25);
        run1("sq_511",      1'b0, 9'd511, 18'd0,    SQB,  SQC,  9'd511, 19'd261121);
        run1("sqrt_25",     1'b1, 9'd0,   18'd25,   SQB,  SQC,  9'd5,   19'd0);
        run1("sqrt_200",    1'b1, 9'd0,   18'd200,  SQB,  SQC,  9'd14,  19'd4);
        run1("sqrt_max",    1'b1, 9'd0,   18'h3FFFF, SQB, SQC,  9'd511, 19'd1022);
        run1("div_35_5",    1'b1, 9'd0,   18'd35,   DIV5, DIV5, 9'd7,   19'd0);
        run1("div_784_5",   1'b1, 9'd0,   18'd784,  DIV5, DIV5, 9'd156, 19'd4);
        run1("div_ovf",     1'b1, 9'd0,   18'd4000, DIV5, DIV5, 9'd511, 19'd1445);
        run1("div_cv0",     1'b1, 9'd0,   18'd1234, 19'd0, 19'd0, 9'h1FF, 19'd1234);
        run1("mul_cv0",     1'b0, 9'h1AB, 18'd777,  19'd0, 19'd0, 9'h1AB, 19'd777);
        run1("mul_wrap",    1'b0, 9'd511, 18'd0,    ONES, ONES, 9'd511, 19'd523777);

        // Back-to-back operations, each result two edges after its inputs.
        apply(1'b0, 9'd5, 18'd0, MUL7, MUL7);
        @(posedge clk); @(negedge clk);
        apply(1'b0, 9'd5, 18'd0, SQB, SQC);
        @(posedge clk); #1 chk("pipe_mul", 9'd5, 19'd35);
        @(negedge clk);
        apply(1'b1, 9'd0, 18'd200, SQB, SQC);
        @(posedge clk); #1 chk("pipe_sq", 9'd5, 19'd25);
        @(negedge clk);
        apply(1'b1, 9'd0, 18'd784, DIV5, DIV5);
        @(posedge clk); #1 chk("pipe_sqrt", 9'd14, 19'd4);
        @(posedge clk); #1 chk("pipe_div", 9'd156, 19'd4);
        @(negedge clk);

        // Reset mid-flight discards the captured operation.
        apply(1'b1, 9'd0, 18'd35, DIV5, DIV5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midreset_async", 9'd0, 19'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("midreset_flush", 9'd0, 19'd0);
        @(posedge clk);
        #1 chk("midreset_after", 9'd7, 19'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpca_cell_array.md
# gpca_cell_array

Registered general-purpose cellular arithmetic array (the `gpca` block). It is a 9-row add/subtract-shift array. One control bit selects the operation class: multiply or square (accumulate), or divide or square root (subtract-compare). The B/C operand words select plain multiplicand/divisor rows or quotient-feedback rows. It sits as a standalone arithmetic unit: operands in, 9-bit multiplier/quotient/root and 19-bit sum/remainder out.

## Interface
- No parameters; all widths fixed.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `X` input 1: operation class. 0 = accumulate (multiply/square); 1 = subtract-compare (divide/square root).
- `P` input [1:9]: multiplier/square operand, bit 1 = MSB, right-justified integer. Ignored when X=1.
- `B` input [1:19]: feedback mask, bit 1 = MSB. Bits set in B but clear in C mark feedback mode.
- `C` input [1:19]: constant operand, left-justified, bit 1 = MSB.
- `A` input [1:18]: right-justified unsigned integer. Addend when X=0; dividend/radicand when X=1.
- `F` output [1:9]: row decision bits, F[1] = MSB. Echoes P when X=0; quotient/root when X=1.
- `S` output [1:19]: right-justified result. Sum mod 2^19 when X=0; remainder when X=1.

## Operation
- Operand decode:
  - Cv = integer formed by C[1..k], where k is the index of the last 1 in C. Cv = 0 if C = 0.
  - FB = OR over (B & ~C). FB=1 is feedback (square/root) mode.
- Row i (i = 1..9):
  - Q_i = integer of F[1..i-1], with Q_1 = 0.
  - Term T_i = Cv when FB=0; T_i = 4·Q_i + Cv when FB=1.
  - Weight W_i = 2^(9-i) when FB=0; 4^(9-i) when FB=1.
- X=0 (accumulate):
  - F[i] = P[i].
  - S = (A + sum over i with P[i]=1 of T_i·W_i) mod 2^19.
  - Examples: multiply with B=C=multiplicand; square with B=0011…1, C=0100…0, giving S = P².
- X=1 (restoring subtract), performed as if rows ran sequentially:
  - R_0 = A.
  - For i = 1..9: if R_{i-1} ≥ T_i·W_i, then F[i]=1 and R_i = R_{i-1} − T_i·W_i; otherwise F[i]=0 and R_i = R_{i-1}.
  - S = R_9 mod 2^19.
  - Divide (FB=0) gives F = floor(A/Cv) when that is < 512.
  - Square root (FB=1, Cv=1) gives F = floor(sqrt(A)) and S = A − F².
- Internal comparisons and products use at least 30-bit width. No intermediate truncation; only the final S is truncated.
- Boundary conditions:
  - Divide overflow (A ≥ 512·Cv) yields F = 9'h1FF and S = (A − 511·Cv) mod 2^19.
  - Cv = 0 with X=1 yields F = 9'h1FF, S = A.
  - Cv = 0 with X=0 yields S = A.

## Timing
- Inputs X, P, A, B, C are captured into input registers on every rising `clk` edge.
- Array evaluation is combinational from those registers. F and S are registered on the next rising edge.
- Latency is 2 cycles: inputs present before edge n produce F/S after edge n+1.
- Fully pipelined: one new operation accepted per cycle; no handshake, no stall.
- While `rst_n` = 0, all input and output registers are 0, so F = 0 and S = 0 immediately (asynchronous).
- Release of `rst_n` takes effect at the next rising edge. First valid output appears 2 edges after the first sampled operands.
- Reset asserted mid-operation discards all in-flight operations.

## Test plan
- Reset: assert `rst_n`=0 with nonzero inputs -> F=0, S=0 without a clock edge; both stay 0 until 2 edges after release.
- Multiply: X=0, P=5, A=0, B=C=19'b111 followed by 16 zeros -> after 2 edges F=5, S=35. Repeat with A=10 -> S=45.
- Square: X=0, P=5, A=0, B=19'b0011…1, C=19'b0100…0 -> F=5, S=25. P=511 -> S=261121.
- Square root: X=1, P=0, A=25, B=0011…1, C=0100…0 -> F=5, S=0. A=200 -> F=14, S=4.
- Divide: X=1, A=35, B=C=19'b101 followed by zeros -> F=7, S=0. A=784 -> F=156, S=4. A=4000, C=101… -> overflow: F=511, S=1445.
- Pipelining: apply the four operations above on consecutive cycles -> results emerge on consecutive cycles in order, each 2 cycles after its inputs.
